spi_loader: RTL and testbench

SPI_LOADER -- requirements
Module: spi_loader

---
 rtl/spi_loader_pkg.sv | 29 ++
 rtl/spi_loader_sync2.sv | 36 +++
 rtl/spi_loader.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_loader_pkg.sv
// -----------------------------------------------------------------------------
// spi_loader_pkg
//   Shared definitions for the SPI register loader: the frame FSM state
//   encoding, the default frame length and the bit layout of the command byte.
//   Command byte layout (MSB first on the wire):
//     bit 7    : W (1 = write data byte to register bank, 0 = read back)
//     bits 6:3 : don't care
//     bits 2:0 : register address
// -----------------------------------------------------------------------------
package spi_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int FRAME_BITS_DEFAULT = 16;

    localparam int CMD_BITS     = 8;
    localparam int CMD_W_BIT    = 7;
    localparam int CMD_ADDR_MSB = 2;
    localparam int CMD_ADDR_LSB = 0;

    localparam int ADDR_W = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;
    localparam int BYTE_W = 8;

endpackage : spi_loader_pkg

// File: rtl/spi_loader_sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a single asynchronous input into the clk domain.
//   Both flops reset to RST_VAL so the synchronized output starts at the idle
//   level of the line it serves.
// Ports:
//   clk_i   - destination clock
//   reset_i - asynchronous active-high reset
//   d_i     - asynchronous input
//   q_o     - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2

// File: rtl/spi_loader.sv
// -----------------------------------------------------------------------------
// spi_loader
//   SPI slave (mode 0) that turns a command byte + data byte frame into a
//   single-cycle write strobe to a small register bank, or serves a readback
//   byte on miso. All SPI inputs are oversampled in the clk domain.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   sclk       - SPI clock (async)
//   cs_n       - SPI chip select, active low (async)
//   mosi       - SPI data in, MSB first (async)
//   read_data  - readback byte from the register bank
//   miso       - SPI data out, MSB first
//   load       - one-clk write strobe, one cycle after data_out updates
//   address    - register address from the last completed command byte
//   data_out   - write data, held after the strobe
//   frame_err  - one-clk pulse when a frame is cut short by cs_n
// -----------------------------------------------------------------------------
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic [BYTE_W-1:0] read_data,
    output logic              miso,
    output logic              load,
    output logic [ADDR_W-1:0] address,
    output logic [BYTE_W-1:0] data_out,
    output logic              frame_err
);

    localparam int              CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;

    sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (sclk),
        .q_o     (sclk_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_cs_n (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (cs_n),
        .q_o     (cs_n_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (mosi),
        .q_o     (mosi_s)
    );

    logic       sclk_prev_q;
    logic       cs_n_prev_q;
    logic [2:0] settle_q;
    logic       settled;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;

    // The synchronizer reset value (cs_n high) is not a real observation of
    // the pin. If cs_n is held low across reset, the chain would show a fake
    // falling edge once reset lifts; cs_n edges are therefore qualified until
    // the chain and the edge register both hold genuine samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
            settle_q    <= 3'b000;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
            settle_q    <= {settle_q[1:0], 1'b1};
        end
    end

    assign settled   = settle_q[2];
    assign cs_fall   = settled &  cs_n_prev_q & ~cs_n_s;
    assign cs_rise   = settled & ~cs_n_prev_q &  cs_n_s;
    // sclk activity only counts while the slave is selected.
    assign sclk_rise = ~cs_n_s &  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~cs_n_s & ~sclk_s &  sclk_prev_q;

    // ------------------------------------------------------------------
    // Frame FSM and datapath state
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [BYTE_W-2:0]   shift_q,     shift_d;
    logic [BYTE_W-1:0]   tx_q,        tx_d;
    logic                miso_q,      miso_d;
    logic                rd_pend_q,   rd_pend_d;
    logic                wr_q,        wr_d;
    logic                load_pend_q, load_pend_d;
    logic                load_q,      load_d;
    logic                frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]   address_q,   address_d;
    logic [BYTE_W-1:0]   data_out_q,  data_out_d;

    // Byte as it stands once the bit being sampled now is shifted in.
    logic [BYTE_W-1:0]   rx_byte;
    assign rx_byte = {shift_q, mosi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        rd_pend_d   = rd_pend_q;
        wr_d        = wr_q;
        load_pend_d = 1'b0;
        load_d      = load_pend_q;
        frame_err_d = 1'b0;
        address_d   = address_q;
        data_out_d  = data_out_q;

        unique case (state_q)
            ST_IDLE: begin
                rd_pend_d = 1'b0;
                miso_d    = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
            end

            ST_CMD: begin
                // A deselect wins over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_d   = rx_byte[BYTE_W-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CMD_LAST) begin
                        address_d = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        wr_d      = rx_byte[CMD_W_BIT];
                        state_d   = ST_DATA;
                        if (!rx_byte[CMD_W_BIT]) begin
                            tx_d      = read_data;
                            rd_pend_d = 1'b1;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    rd_pend_d   = 1'b0;
                    miso_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    if (sclk_fall && rd_pend_q) begin
                        miso_d = tx_q[BYTE_W-1];
                        tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_d   = rx_byte[BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == FRAME_LAST) begin
                            state_d   = ST_DONE;
                            rd_pend_d = 1'b0;
                            miso_d    = 1'b0;
                            if (wr_q) begin
                                data_out_d  = rx_byte;
                                load_pend_d = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                // Trailing bits of an overlong frame are dropped here.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_q        <= 1'b0;
            load_pend_q <= 1'b0;
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
            address_q   <= '0;
            data_out_q  <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            rd_pend_q   <= rd_pend_d;
            wr_q        <= wr_d;
            load_pend_q <= load_pend_d;
            load_q      <= load_d;
            frame_err_q <= frame_err_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign miso      = (state_q == ST_DATA && rd_pend_q) ? miso_q : 1'b0;
    assign load      = load_q;
    assign frame_err = frame_err_q;
    assign address   = address_q;
    assign data_out  = data_out_q;

endmodule : spi_loader

// File: tb/tb_spi_loader.sv
module tb_spi_loader;

    localparam int HALF = 8;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } ld_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] read_data = 8'h00;
    logic       miso;
    logic       load;
    logic [2:0] address;
    logic [7:0] data_out;
    logic       frame_err;

    int vectors = 0;
    int miscompares = 0;
    int load_cnt = 0;
    int ferr_cnt = 0;
    ld_t exp_q[$];

    spi_loader #(.FRAME_BITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .read_data (read_data),
        .miso      (miso),
        .load      (load),
        .address   (address),
        .data_out  (data_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every load strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("load_unexpected", 32'd1, 32'd0);
            end else begin
                ld_t e;
                e = exp_q.pop_front();
                check_eq("load_addr", 32'(address), 32'(e.addr));
                check_eq("load_data", 32'(data_out), 32'(e.data));
            end
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [7:0] d);
        ld_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Shift n bits of a left-aligned 24-bit word, MSB first. Optionally
    // compare miso against rd_exp during the data byte, sampled just before
    // each sclk rise as a mode-0 master would.
    task automatic send_bits(input logic [23:0] bits, input int n,
                             input logic [7:0] rd_exp, input bit chk_miso);
        for (int i = 0; i < n; i++) begin
            mosi = bits[23-i];
            tick(HALF);
            if (chk_miso && i >= 8 && i < 16)
                check_eq($sformatf("miso_bit%0d", 15 - i), 32'(miso), 32'(rd_exp[15-i]));
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_load"},      32'(load),      32'd0);
        check_eq({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
        check_eq({pfx, "_miso"},      32'(miso),      32'd0);
        check_eq({pfx, "_address"},   32'(address),   32'd0);
        check_eq({pfx, "_data_out"},  32'(data_out),  32'd0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(5);

        // Write 0x5A to register 4.
        push_exp(3'd4, 8'h5A);
        frame_start();
        send_bits(24'h845A00, 16, 8'h00, 1'b0);
        frame_end();
        check_eq("wr_address",  32'(address),  32'd4);
        check_eq("wr_data_out", 32'(data_out), 32'h5A);
        check_eq("wr_load_cnt", 32'(load_cnt), 32'd1);
        check_eq("wr_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Read register 5 with readback 0xC3.
        read_data = 8'hC3;
        frame_start();
        send_bits(24'h050000, 16, 8'hC3, 1'b1);
        frame_end();
        check_eq("rd_address",  32'(address),  32'd5);
        check_eq("rd_data_out", 32'(data_out), 32'h5A);
        check_eq("rd_miso_idle", 32'(miso),    32'd0);
        check_eq("rd_load_cnt", 32'(load_cnt), 32'd1);

        // Abort after 11 bits: command completed, data byte cut short.
        frame_start();
        send_bits(24'h86FF00, 11, 8'h00, 1'b0);
        frame_end();
        check_eq("ab_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check_eq("ab_data_out", 32'(data_out), 32'h5A);
        check_eq("ab_address",  32'(address),  32'd6);
        check_eq("ab_load_cnt", 32'(load_cnt), 32'd1);

        // Overlong 24-bit frame: trailing byte dropped.
        push_exp(3'd2, 8'h20);
        frame_start();
        send_bits(24'h8220FF, 24, 8'h00, 1'b0);
        frame_end();
        check_eq("ol_data_out", 32'(data_out), 32'h20);
        check_eq("ol_address",  32'(address),  32'd2);
        check_eq("ol_load_cnt", 32'(load_cnt), 32'd2);
        check_eq("ol_ferr_cnt", 32'(ferr_cnt), 32'd1);

        // Reset in the middle of a write frame, cs_n still low.
        frame_start();
        send_bits(24'h87AB00, 12, 8'h00, 1'b0);
        reset = 1'b1;
        tick(2);
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        tick(4);
        cs_n = 1'b1;
        tick(2 * HALF);
        check_eq("mr_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check_eq("mr_load_cnt", 32'(load_cnt), 32'd2);
        check_eq("mr_address",  32'(address),  32'd0);
        push_exp(3'd3, 8'h11);
        frame_start();
        send_bits(24'h831100, 16, 8'h00, 1'b0);
        frame_end();
        check_eq("mr_wr_address",  32'(address),  32'd3);
        check_eq("mr_wr_data_out", 32'(data_out), 32'h11);
        check_eq("mr_wr_load_cnt", 32'(load_cnt), 32'd3);

        // Back-to-back frames separated by a one-clk cs_n high gap.
        push_exp(3'd2, 8'h20);
        push_exp(3'd3, 8'h00);
        frame_start();
        send_bits(24'h822000, 16, 8'h00, 1'b0);
        tick(HALF);
        cs_n = 1'b1;
        tick(1);
        cs_n = 1'b0;
        tick(HALF);
        send_bits(24'h830000, 16, 8'h00, 1'b0);
        frame_end();
        check_eq("bb_load_cnt", 32'(load_cnt), 32'd5);
        check_eq("bb_address",  32'(address),  32'd3);
        check_eq("bb_data_out", 32'(data_out), 32'h00);
        check_eq("bb_ferr_cnt", 32'(ferr_cnt), 32'd1);

        tick(10);
        check_eq("loads_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_spi_loader
